// File: rtl/prog_ram_loader.sv
// prog_ram_loader: run-time program store writer.
//   Accepts DEPTH program words over a valid/ready stream after a load_start
//   pulse and writes them sequentially into a small RAM. The CPU reads the RAM
//   combinationally through address/data, exactly like a fixed program store.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   load_start     1-cycle pulse, starts a load session at word 0 (IDLE/DONE only)
//   in_data/in_valid/in_ready  program word stream
//   address/data   CPU fetch port, data = mem[address] (combinational)
//   loading        high while loading words
//   done           high after a complete load until next load_start or reset
//   checksum       running modulo-2**DATA_WIDTH sum of accepted words
//                  (only when LOADER_CHECKSUM_EN is defined)
// Optional feature macro: LOADER_CHECKSUM_EN
module prog_ram_loader #(
    parameter int unsigned ADDR_WIDTH = 2,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_start,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  loading,
    output logic                  done
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] checksum
`endif
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic                  in_ready_q, in_ready_d;
    logic                  loading_q, loading_d;
    logic                  done_q, done_d;
    logic                  accept_c;
    logic                  start_load_c;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // in_ready_q is only set in LOAD, so this is the stream handshake
    assign accept_c = in_valid & in_ready_q;

    // Next-state logic; status flags are decoded from the next state so the
    // registered versions track the state register exactly.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        start_load_c = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (load_start) begin
                    state_d      = ST_LOAD;
                    wr_ptr_d     = '0;
                    start_load_c = 1'b1;
                end
            end
            ST_LOAD: begin
                if (accept_c) begin
                    wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
                    if (wr_ptr_q == ADDR_WIDTH'(DEPTH - 1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        in_ready_d = (state_d == ST_LOAD);
        loading_d  = (state_d == ST_LOAD);
        done_d     = (state_d == ST_DONE);
    end

    // Control state with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            in_ready_q <= 1'b0;
            loading_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            in_ready_q <= in_ready_d;
            loading_q  <= loading_d;
            done_q     <= done_d;
        end
    end

    // Program RAM: contents survive reset; a reset edge never writes
    always_ff @(posedge clk) begin
        if (rst_n && accept_c) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign data     = mem_q[address];
    assign in_ready = in_ready_q;
    assign loading  = loading_q;
    assign done     = done_q;

`ifdef LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] checksum_q, checksum_d;

    // Sum restarts when a session begins and accumulates each accepted word
    always_comb begin
        checksum_d = checksum_q;
        if (start_load_c) begin
            checksum_d = '0;
        end else if (accept_c) begin
            checksum_d = checksum_q + in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    logic unused_start_load_c;
    assign unused_start_load_c = start_load_c;
`endif

endmodule

// File: tb/tb_prog_ram_loader.sv
// Testbench for prog_ram_loader: directed session scenarios followed by
// randomized traffic, all checked against a session-level reference model
// (accept counter, stored-word array, running sum) kept in the bench.
module tb_prog_ram_loader;

    localparam int unsigned AW    = 2;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load_start;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] address;
    logic [DW-1:0] data;
    logic          loading;
    logic          done;
`ifdef LOADER_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    always #5 clk = ~clk;

    prog_ram_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .address    (address),
        .data       (data),
        .loading    (loading),
        .done       (done)
`ifdef LOADER_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: session flags, words accepted this session, RAM image
    bit            m_active;
    bit            m_done;
    int            m_cnt;
    logic [DW-1:0] m_sum;
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_known [DEPTH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("in_ready", 32'(in_ready), 32'(m_active));
        chk("loading", 32'(loading), 32'(m_active));
        chk("done", 32'(done), 32'(m_done));
        if (m_known[address]) chk("data", 32'(data), 32'(m_mem[address]));
`ifdef LOADER_CHECKSUM_EN
        chk("checksum", 32'(checksum), 32'(m_sum));
`endif
    endtask

    // Advance the model by one rising edge using the currently driven inputs
    task automatic model_edge();
        if (!rst_n) begin
            m_active = 1'b0;
            m_done   = 1'b0;
            m_cnt    = 0;
            m_sum    = '0;
        end else if (m_active) begin
            if (in_valid) begin
                m_mem[m_cnt]   = in_data;
                m_known[m_cnt] = 1'b1;
                m_sum          = DW'(m_sum + in_data);
                m_cnt          = m_cnt + 1;
                if (m_cnt == DEPTH) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                    m_cnt    = 0;
                end
            end
        end else if (load_start) begin
            m_active = 1'b1;
            m_done   = 1'b0;
            m_cnt    = 0;
            m_sum    = '0;
        end
    endtask

    // One clock cycle: drive, check current outputs, advance model, take edge
    task automatic step(input bit start, input bit valid, input logic [DW-1:0] d,
                        input logic [AW-1:0] a);
        load_start = start;
        in_valid   = valid;
        in_data    = d;
        address    = a;
        #1;
        check_all();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    // Idle cycle that also checks the addressed word against a fixed value
    task automatic rd(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        load_start = 1'b0;
        in_valid   = 1'b0;
        address    = a;
        #1;
        chk(tag, 32'(data), 32'(exp));
        check_all();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DW-1:0] t1 [DEPTH];
        bit            gaps [7];
        int            k;

        t1   = '{8'h10, 8'h30, 8'h40, 8'h40};
        gaps = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;

        // Reset prelude: outputs undefined before the first reset edge
        rst_n = 1'b0; load_start = 1'b0; in_valid = 1'b0; in_data = '0; address = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        model_edge();
        rst_n = 1'b1;
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        chk("reset_done", 32'(done), 32'd0);

        // 1: back-to-back load
        step(1'b1, 1'b0, '0, '0);
        chk("t1_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, t1[i], AW'(i));
        chk("t1_done", 32'(done), 32'd1);
`ifdef LOADER_CHECKSUM_EN
        chk("t1_checksum", 32'(checksum), 32'hC0);
`endif
        for (int i = 0; i < DEPTH; i++) rd("t1_read", AW'(i), t1[i]);

        // 2: same stream with valid gaps
        step(1'b1, 1'b0, '0, '0);
        k = 0;
        for (int i = 0; i < 7; i++) begin
            step(1'b0, gaps[i], gaps[i] ? t1[k] : 8'hEE, AW'(k));
            if (gaps[i]) k++;
        end
        chk("t2_done", 32'(done), 32'd1);
        for (int i = 0; i < DEPTH; i++) rd("t2_read", AW'(i), t1[i]);

        // 3: stream ignored in DONE, then restart with 01..04
        step(1'b0, 1'b1, 8'hFF, 2'd0);
        step(1'b0, 1'b1, 8'hFF, 2'd1);
        chk("t3_done_hold", 32'(done), 32'd1);
        rd("t3_no_write", 2'd0, 8'h10);
        step(1'b1, 1'b0, '0, '0);
        chk("t3_restart_done", 32'(done), 32'd0);
        chk("t3_restart_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, DW'(i + 1), AW'(i));
`ifdef LOADER_CHECKSUM_EN
        chk("t3_checksum", 32'(checksum), 32'h0A);
`endif

        // 4: reset after two accepts; valid during reset must not write
        step(1'b1, 1'b0, '0, '0);
        step(1'b0, 1'b1, 8'hAA, 2'd0);
        step(1'b0, 1'b1, 8'hBB, 2'd1);
        rst_n = 1'b0;
        step(1'b0, 1'b1, 8'hCC, 2'd2);
        rst_n = 1'b1;
        chk("t4_done", 32'(done), 32'd0);
        chk("t4_in_ready", 32'(in_ready), 32'd0);
        rd("t4_addr0", 2'd0, 8'hAA);
        rd("t4_addr1", 2'd1, 8'hBB);
        rd("t4_addr2", 2'd2, 8'h03);
        rd("t4_addr3", 2'd3, 8'h04);

        // 5: load_start during LOAD is ignored
        step(1'b1, 1'b0, '0, '0);
        step(1'b0, 1'b1, 8'h11, 2'd0);
        step(1'b1, 1'b0, '0, '0);
        step(1'b0, 1'b1, 8'h22, 2'd1);
        step(1'b0, 1'b1, 8'h33, 2'd2);
        chk("t5_not_done", 32'(done), 32'd0);
        step(1'b0, 1'b1, 8'h44, 2'd3);
        chk("t5_done", 32'(done), 32'd1);
        rd("t5_addr1", 2'd1, 8'h22);

        // 6: read during write returns old word, new word next cycle
        step(1'b1, 1'b0, '0, '0);
        load_start = 1'b0; in_valid = 1'b1; in_data = 8'h5A; address = 2'd0;
        #1;
        chk("t6_old", 32'(data), 32'h11);
        check_all();
        model_edge();
        @(posedge clk); #1;
        rd("t6_new", 2'd0, 8'h5A);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 39) != 0);
            step($urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0,
                 DW'($urandom), AW'($urandom));
            rst_n = 1'b1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
